// File: rtl/vab_pkg.sv
// Shared types for the valid/a/b transmit sequencer.
package vab_pkg;
   typedef enum logic [2:0] {IDLE, VLD, APH, WAIT, BPH, GAP} vab_state_t;
   localparam int DLY_W = 4;
endpackage

// File: rtl/vab_seq_driver_fifo.sv
// Pending-request queue: 1-bit wide sync FIFO holding the inject_err flag per request.
module vab_req_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic push_data,
   input  logic pop,
   output logic pop_data,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0] mem_q, mem_d;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/vab_seq_driver.sv
// Transmit side of valid/a/b: queues requests and drives valid, a, then b A2B_DLY later.
//  state | meaning
//  IDLE  | queue empty, waiting for a request
//  VLD   | valid high, entry popped and err latched
//  APH   | a high
//  WAIT  | counting down the a-to-b delay
//  BPH   | b high (unless err), done pulse, count completed txn
//  GAP   | idle spacing before the next valid
module vab_seq_driver #(
   parameter int A2B_DLY = 3,
   parameter int GAP     = 0,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             start_ready,
   input  logic             inject_err,
   output logic             valid,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] txn_count
);
   import vab_pkg::*;

   // The GAP parameter shadows the enum literal of the same name.
   localparam vab_state_t ST_GAP = vab_pkg::GAP;

   vab_state_t       state_q, state_d;
   logic [DLY_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, a_q, b_q, busy_q, done_q;
   logic             q_full, q_empty, q_data, pop;

   assign start_ready = !q_full;

   vab_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (start && !q_full),
      .push_data (inject_err),
      .pop       (pop),
      .pop_data  (q_data),
      .full      (q_full),
      .empty     (q_empty)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      count_d = count_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!q_empty) begin
               state_d = VLD;
               pop     = 1'b1;
               err_d   = q_data;
            end
         end
         VLD:  state_d = APH;
         APH: begin
            if (A2B_DLY == 1) begin
               state_d = BPH;
            end else begin
               state_d = WAIT;
               cnt_d   = DLY_W'(A2B_DLY - 1);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - DLY_W'(1);
            if (cnt_q == DLY_W'(1)) state_d = BPH;
         end
         BPH: begin
            if (GAP > 0) begin
               state_d = ST_GAP;
               cnt_d   = DLY_W'(GAP);
            end else if (!q_empty) begin
               state_d = VLD;
               pop     = 1'b1;
               err_d   = q_data;
            end else begin
               state_d = IDLE;
            end
         end
         ST_GAP: begin
            cnt_d = cnt_q - DLY_W'(1);
            if (cnt_q == DLY_W'(1)) begin
               if (!q_empty) begin
                  state_d = VLD;
                  pop     = 1'b1;
                  err_d   = q_data;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == BPH) count_d = count_q + CNT_W'(1);
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
         valid_q <= 1'b0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         count_q <= count_d;
         valid_q <= (state_d == VLD);
         a_q     <= (state_d == APH);
         b_q     <= (state_d == BPH) && !err_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == BPH);
      end
   end

   assign valid     = valid_q;
   assign a         = a_q;
   assign b         = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign txn_count = count_q;
endmodule

// File: tb/tb_vab_seq_driver.sv
// Directed bench for vab_seq_driver: default instance plus a GAP=2/A2B_DLY=1/CNT_W=2 instance.
module tb_vab_seq_driver;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n1, start1, inj1, rdy1, v1, a1, b1, busy1, done1;
   logic [7:0] cnt1;
   logic       rst_n2, start2, inj2, rdy2, v2, a2, b2, busy2, done2;
   logic [1:0] cnt2;

   vab_seq_driver u_dut1 (
      .clk(clk), .rst_n(rst_n1), .start(start1), .start_ready(rdy1), .inject_err(inj1),
      .valid(v1), .a(a1), .b(b1), .busy(busy1), .done(done1), .txn_count(cnt1)
   );

   vab_seq_driver #(.A2B_DLY(1), .GAP(2), .DEPTH(4), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n2), .start(start2), .start_ready(rdy2), .inject_err(inj2),
      .valid(v2), .a(a2), .b(b2), .busy(busy2), .done(done2), .txn_count(cnt2)
   );

   typedef struct packed {
      logic       v;
      logic       a;
      logic       b;
      logic       d;
      logic       busy;
      logic       rdy;
      logic [7:0] cnt;
   } smp_t;

   smp_t trace[$];
   int   cnt_seq[$];
   bit   log_en = 1'b0;
   bit   sel2   = 1'b0;
   int   n_chk  = 0;
   int   n_err  = 0;
   int   mon_off;

   always @(posedge clk) begin
      #1;
      if (log_en)
         trace.push_back(sel2 ? smp_t'({v2, a2, b2, done2, busy2, rdy2, 6'd0, cnt2})
                              : smp_t'({v1, a1, b1, done1, busy1, rdy1, cnt1}));
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit fld(smp_t s, int f);
      case (f)
         0:       return s.v;
         1:       return s.a;
         2:       return s.b;
         3:       return s.d;
         4:       return s.busy;
         default: return s.rdy;
      endcase
   endfunction

   function automatic int first_idx(int f, int from);
      for (int i = from; i < trace.size(); i++)
         if (fld(trace[i], f)) return i;
      return -1;
   endfunction

   function automatic int n_set(int f);
      int n = 0;
      foreach (trace[i]) if (fld(trace[i], f)) n++;
      return n;
   endfunction

   // Receiver-side property valid |=> (a ##dly b); mon_off: 1 = a missing, 2 = b missing.
   function automatic int mon_fails(int dly);
      int fails = 0;
      mon_off = 0;
      for (int i = 0; i < trace.size(); i++) begin
         if (trace[i].v) begin
            if (i + 1 < trace.size() && !trace[i+1].a) begin
               fails++;
               mon_off = 1;
            end else if (i + 1 + dly < trace.size() && !trace[i+1+dly].b) begin
               fails++;
               mon_off = 2;
            end
         end
      end
      return fails;
   endfunction

   function automatic int overlaps();
      int n = 0;
      foreach (trace[i]) if (trace[i].v && (trace[i].a || trace[i].b)) n++;
      return n;
   endfunction

   task automatic grab_counts();
      foreach (trace[i]) if (trace[i].d) cnt_seq.push_back(int'(trace[i].cnt));
   endtask

   initial begin
      int exp_v[5];
      int exp_seq[5];
      int prev;
      exp_v   = '{1, 6, 11, 16, 21};
      exp_seq = '{1, 2, 3, 0, 1};
      rst_n1 = 1'b0; rst_n2 = 1'b0;
      start1 = 1'b0; inj1 = 1'b0; start2 = 1'b0; inj2 = 1'b0;
      run(2);
      chk("rst_outs", int'({v1, a1, b1, done1, busy1}), 0);
      chk("rst_cnt", int'(cnt1), 0);
      chk("rst_ready", int'(rdy1), 1);
      chk("rst_cnt2", int'(cnt2), 0);
      rst_n1 = 1'b1; rst_n2 = 1'b1;
      run(2);

      // single transaction
      sel2 = 1'b0; trace.delete(); log_en = 1'b1; start1 = 1'b1;
      run(1); start1 = 1'b0;
      run(10); log_en = 1'b0;
      chk("single_valid_at", first_idx(0, 0), 1);
      chk("single_a_at", first_idx(1, 0), 2);
      chk("single_b_at", first_idx(2, 0), 5);
      chk("single_done_at", first_idx(3, 0), 5);
      chk("single_nvalid", n_set(0), 1);
      chk("single_mon", mon_fails(3), 0);
      chk("single_cnt", int'(cnt1), 1);

      // error injection: b suppressed, done still pulses
      trace.delete(); log_en = 1'b1; start1 = 1'b1; inj1 = 1'b1;
      run(1); start1 = 1'b0; inj1 = 1'b0;
      run(10); log_en = 1'b0;
      chk("err_valid_at", first_idx(0, 0), 1);
      chk("err_a_at", first_idx(1, 0), 2);
      chk("err_nb", n_set(2), 0);
      chk("err_done_at", first_idx(3, 0), 5);
      chk("err_mon_fails", mon_fails(3), 1);
      chk("err_mon_off", mon_off, 2);
      chk("err_cnt", int'(cnt1), 2);

      // back-to-back: 6 attempts, 6th hits a full queue (its inject_err must be ignored)
      trace.delete(); log_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         start1 = 1'b1; inj1 = (k == 5);
         run(1);
      end
      start1 = 1'b0; inj1 = 1'b0;
      run(26); log_en = 1'b0;
      chk("b2b_rdy3", int'(trace[3].rdy), 1);
      chk("b2b_rdy4", int'(trace[4].rdy), 0);
      chk("b2b_rdy5", int'(trace[5].rdy), 0);
      chk("b2b_rdy6", int'(trace[6].rdy), 1);
      chk("b2b_nvalid", n_set(0), 5);
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("b2b_valid%0d", k), first_idx(0, prev), exp_v[k]);
         prev = exp_v[k] + 1;
      end
      chk("b2b_nb", n_set(2), 5);
      chk("b2b_overlap", overlaps(), 0);
      chk("b2b_mon", mon_fails(3), 0);
      chk("b2b_cnt", int'(cnt1), 7);

      // reset while waiting for b
      trace.delete(); log_en = 1'b1; start1 = 1'b1;
      run(1); start1 = 1'b0;
      run(3);
      chk("rmid_busy_pre", int'(trace[3].busy), 1);
      rst_n1 = 1'b0;
      #1;
      chk("rmid_outs", int'({v1, a1, b1, done1, busy1}), 0);
      chk("rmid_cnt", int'(cnt1), 0);
      chk("rmid_ready", int'(rdy1), 1);
      run(2); rst_n1 = 1'b1;
      run(8); log_en = 1'b0;
      chk("rmid_nb", n_set(2), 0);
      chk("rmid_ndone", n_set(3), 0);
      chk("rmid_cnt_post", int'(cnt1), 0);

      // GAP=2, A2B_DLY=1: two queued requests
      sel2 = 1'b1; trace.delete(); log_en = 1'b1; start2 = 1'b1;
      run(2); start2 = 1'b0;
      run(12); log_en = 1'b0;
      chk("gap_valid_at", first_idx(0, 0), 1);
      chk("gap_a_at", first_idx(1, 0), 2);
      chk("gap_b_at", first_idx(2, 0), 3);
      chk("gap_idle4", int'({trace[4].v, trace[4].a, trace[4].b, trace[4].busy}), 1);
      chk("gap_idle5", int'({trace[5].v, trace[5].a, trace[5].b, trace[5].busy}), 1);
      chk("gap_valid2_at", first_idx(0, 2), 6);
      chk("gap_b2_at", first_idx(2, 4), 8);
      chk("gap_nvalid", n_set(0), 2);
      chk("gap_busy_end", int'(trace[11].busy), 0);
      chk("gap_mon", mon_fails(1), 0);
      grab_counts();

      // counter wrap at CNT_W=2
      trace.delete(); log_en = 1'b1; start2 = 1'b1;
      run(3); start2 = 1'b0;
      run(20); log_en = 1'b0;
      grab_counts();
      chk("wrap_ndone", cnt_seq.size(), 5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("wrap_seq%0d", k), (k < cnt_seq.size()) ? cnt_seq[k] : -1, exp_seq[k]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
